id_exe_reg: RTL and testbench
=============================

# id_exe_reg

Pipeline register between the instruction-decode (ID) and execute (EXE) stages. It captures the decoded control word, operand values, and register addresses every cycle. It holds them under a stall and turns them into a bubble under a flush. Its `exe_src1`, `exe_src2` and `exe_dest`/`exe_wb_en` outputs feed the EXE-stage operand muxes and the forwarding unit, which compares them against MEM/WB destinations.

## Interface
Parameters:
- `DATA_W`, 32, width of PC and operand values
- `REG_W`, 4, register-address width (16 architectural registers)

Ports:
- `clk`  in  1  rising-edge clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  branch taken: next captured word is a bubble
- `freeze`  in  1  hazard stall: hold all outputs
- `id_wb_en`, `id_mem_r_en`, `id_mem_w_en`, `id_b`, `id_s`  in  1 each  decoded control bits
- `id_exe_cmd`  in  4  ALU command
- `id_pc`  in  DATA_W  PC+4 of the instruction
- `id_val_rn`, `id_val_rm`  in  DATA_W  register-file read values
- `id_imm`  in  1  immediate-operand flag
- `id_shift_operand`  in  12  shifter operand field
- `id_signed_imm_24`  in  24  branch offset
- `id_dest`, `id_src1`, `id_src2`  in  REG_W  destination and source register numbers
- `id_sr`  in  4  status flags (N,Z,C,V) at decode
- `exe_*`  out  same widths  registered copies of every `id_*` input above
- `exe_valid`  out  1  1 = `exe_*` holds a real instruction, 0 = bubble

## Operation
- Priority each rising edge: `rst` > `flush` > `freeze` > load.
- Reset:
  - All `exe_*` outputs become 0, including `exe_valid`.
  - Every field is cleared, not only the control bits.
- Flush:
  - Control bits `exe_wb_en`, `exe_mem_r_en`, `exe_mem_w_en`, `exe_b` and `exe_s` are forced to 0.
  - `exe_exe_cmd` is forced to 0 and `exe_valid` to 0.
  - Address fields `exe_dest`, `exe_src1` and `exe_src2` are forced to 0.
  - Data fields (`pc`, `val_rn`, `val_rm`, `shift_operand`, `signed_imm_24`, `imm`, `sr`) are also cleared to 0.
  - Flush overrides `freeze` in the same cycle.
- Freeze (without flush): every output register keeps its value, `exe_valid` included.
- Load (neither asserted): every `exe_*` output takes its `id_*` input and `exe_valid` becomes 1.
- No combinational path from any input to any output. All outputs are flop outputs.
- A bubble must never cause a writeback, a memory access, a branch or a flag update. This holds because the control bits are 0.
- Widths are copied exactly; there is no sign extension or arithmetic in this block.

## Timing
- Latency: exactly 1 cycle from `id_*` to `exe_*` on load.
- Reset state after the first rising edge with `rst`=1: all outputs 0. This state persists while `rst` stays high, regardless of `flush` and `freeze`.
- Leaving reset: the first edge with `rst`=0 and `freeze`=0 loads the ID values.
- `freeze` held for N cycles: outputs are unchanged for N edges. The edge after `freeze` drops loads the current `id_*` values; no value is lost or duplicated.
- `flush` for one cycle: exactly one bubble (`exe_valid`=0) appears for one cycle. The following edge loads normally unless frozen.
- `flush` and `freeze` asserted together: a bubble is inserted.
- `freeze` asserted while a bubble is held: the bubble persists.
- `rst` asserted mid-stall or mid-flush: outputs are 0 on that edge.

## Test plan
- Reset: drive all `id_*` to all-ones with `rst`=1 for 2 cycles. Required: every `exe_*` is 0 and `exe_valid`=0. Then release `rst`: one edge later `exe_dest`=4'hF, `exe_val_rn`=32'hFFFFFFFF and `exe_valid`=1.
- Load latency: apply `id_src1`=3, `id_src2`=5, `id_dest`=7, `id_wb_en`=1, `id_exe_cmd`=4'h2, `id_val_rn`=32'h10. Required: exactly one edge later the same values appear on `exe_*` with `exe_valid`=1.
- Freeze: load `id_dest`=7, then raise `freeze` for 3 cycles while `id_dest` walks 8, 9, A. Required:
  - `exe_dest` stays 7 for all 3 cycles.
  - After `freeze` falls, `exe_dest`=A one edge later.
- Flush: load an instruction with `id_wb_en`=1, `id_mem_w_en`=1, `id_dest`=2, then pulse `flush` one cycle. Required:
  - The next edge gives `exe_wb_en`=0, `exe_mem_w_en`=0, `exe_dest`=0, `exe_valid`=0.
  - The edge after that loads the new `id_*` values.
- Flush with freeze: assert both for one cycle. Required: bubble (`exe_valid`=0, all controls 0). Then hold `freeze` alone for 2 cycles: the bubble is held. Then release `freeze`: the next instruction loads.
- Reset mid-stall: `freeze`=1 with `exe_dest`=6, then pulse `rst` one cycle. Required: all outputs are 0 on that edge and remain 0 until a load edge occurs with `freeze`=0.

Source files
------------

// File: rtl/id_exe_reg_if.sv
// id_exe_reg_if: bundle of signals between the ID stage and the ID/EXE
// pipeline register.
//   master : drives flush/freeze and the id_* word, observes exe_*
//   slave  : the pipeline register; samples id_*, drives exe_* and exe_valid
interface id_exe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);
  logic              flush;
  logic              freeze;

  logic              id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
  logic [3:0]        id_exe_cmd;
  logic [DATA_W-1:0] id_pc, id_val_rn, id_val_rm;
  logic              id_imm;
  logic [11:0]       id_shift_operand;
  logic [23:0]       id_signed_imm_24;
  logic [REG_W-1:0]  id_dest, id_src1, id_src2;
  logic [3:0]        id_sr;

  logic              exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s;
  logic [3:0]        exe_exe_cmd;
  logic [DATA_W-1:0] exe_pc, exe_val_rn, exe_val_rm;
  logic              exe_imm;
  logic [11:0]       exe_shift_operand;
  logic [23:0]       exe_signed_imm_24;
  logic [REG_W-1:0]  exe_dest, exe_src1, exe_src2;
  logic [3:0]        exe_sr;
  logic              exe_valid;

  modport master (
    output flush, freeze,
    output id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_exe_cmd,
    output id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
    output id_signed_imm_24, id_dest, id_src1, id_src2, id_sr,
    input  exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_exe_cmd,
    input  exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
    input  exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_sr, exe_valid
  );

  modport slave (
    input  flush, freeze,
    input  id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_exe_cmd,
    input  id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
    input  id_signed_imm_24, id_dest, id_src1, id_src2, id_sr,
    output exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_exe_cmd,
    output exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
    output exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_sr, exe_valid
  );
endinterface

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every output
//   bus  : id_exe_reg_if.slave -- flush/freeze, id_* word in, exe_* word
//          and exe_valid out
// Per edge, priority rst > flush > freeze > load. Flush clears the whole
// word (not only the control bits), so a bubble is indistinguishable from
// the reset state and can never write back, access memory, branch or set
// flags. All outputs come straight from flops.
module id_exe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  id_exe_reg_if.slave  bus
);
  localparam int W = 5 + 4 + 3*DATA_W + 1 + 12 + 24 + 3*REG_W + 4;

  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         valid_q;

  assign d = {bus.id_wb_en, bus.id_mem_r_en, bus.id_mem_w_en, bus.id_b, bus.id_s,
              bus.id_exe_cmd, bus.id_pc, bus.id_val_rn, bus.id_val_rm,
              bus.id_imm, bus.id_shift_operand, bus.id_signed_imm_24,
              bus.id_dest, bus.id_src1, bus.id_src2, bus.id_sr};

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      q       <= '0;
      valid_q <= 1'b0;
    end else if (!bus.freeze) begin
      q       <= d;
      valid_q <= 1'b1;
    end
  end

  assign {bus.exe_wb_en, bus.exe_mem_r_en, bus.exe_mem_w_en, bus.exe_b, bus.exe_s,
          bus.exe_exe_cmd, bus.exe_pc, bus.exe_val_rn, bus.exe_val_rm,
          bus.exe_imm, bus.exe_shift_operand, bus.exe_signed_imm_24,
          bus.exe_dest, bus.exe_src1, bus.exe_src2, bus.exe_sr} = q;
  assign bus.exe_valid = valid_q;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed bench for id_exe_reg with hand-computed expectations.
module tb_id_exe_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int W      = 5 + 4 + 3*DATA_W + 1 + 12 + 24 + 3*REG_W + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  id_exe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus_if ();

  id_exe_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  function automatic logic [159:0] exe_word();
    return 160'({bus_if.exe_wb_en, bus_if.exe_mem_r_en, bus_if.exe_mem_w_en,
                 bus_if.exe_b, bus_if.exe_s, bus_if.exe_exe_cmd, bus_if.exe_pc,
                 bus_if.exe_val_rn, bus_if.exe_val_rm, bus_if.exe_imm,
                 bus_if.exe_shift_operand, bus_if.exe_signed_imm_24,
                 bus_if.exe_dest, bus_if.exe_src1, bus_if.exe_src2, bus_if.exe_sr});
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v);
    bus_if.id_wb_en         = v;
    bus_if.id_mem_r_en      = v;
    bus_if.id_mem_w_en      = v;
    bus_if.id_b             = v;
    bus_if.id_s             = v;
    bus_if.id_exe_cmd       = {4{v}};
    bus_if.id_pc            = {DATA_W{v}};
    bus_if.id_val_rn        = {DATA_W{v}};
    bus_if.id_val_rm        = {DATA_W{v}};
    bus_if.id_imm           = v;
    bus_if.id_shift_operand = {12{v}};
    bus_if.id_signed_imm_24 = {24{v}};
    bus_if.id_dest          = {REG_W{v}};
    bus_if.id_src1          = {REG_W{v}};
    bus_if.id_src2          = {REG_W{v}};
    bus_if.id_sr            = {4{v}};
  endtask

  initial begin
    logic [W-1:0]   ones;
    logic [159:0]   exp_word;
    ones = '1;

    bus_if.flush  = 1'b0;
    bus_if.freeze = 1'b0;
    set_id(1'b1);

    // reset with all-ones inputs; second cycle also has flush+freeze high
    step();
    chk("rst1_word",  exe_word(), 160'(0));
    chk("rst1_valid", 160'(bus_if.exe_valid), 160'(0));
    bus_if.flush  = 1'b1;
    bus_if.freeze = 1'b1;
    step();
    chk("rst2_word",  exe_word(), 160'(0));
    chk("rst2_valid", 160'(bus_if.exe_valid), 160'(0));

    // leave reset
    bus_if.flush  = 1'b0;
    bus_if.freeze = 1'b0;
    rst = 1'b0;
    step();
    chk("rel_dest",   160'(bus_if.exe_dest), 160'(4'hF));
    chk("rel_val_rn", 160'(bus_if.exe_val_rn), 160'(32'hFFFF_FFFF));
    chk("rel_valid",  160'(bus_if.exe_valid), 160'(1));
    chk("rel_word",   exe_word(), 160'(ones));

    // load latency
    set_id(1'b0);
    bus_if.id_src1    = 4'd3;
    bus_if.id_src2    = 4'd5;
    bus_if.id_dest    = 4'd7;
    bus_if.id_wb_en   = 1'b1;
    bus_if.id_exe_cmd = 4'h2;
    bus_if.id_val_rn  = 32'h10;
    #1;
    chk("no_comb_path", 160'(bus_if.exe_dest), 160'(4'hF));
    step();
    chk("ld_src1",  160'(bus_if.exe_src1), 160'(3));
    chk("ld_src2",  160'(bus_if.exe_src2), 160'(5));
    chk("ld_dest",  160'(bus_if.exe_dest), 160'(7));
    chk("ld_wb_en", 160'(bus_if.exe_wb_en), 160'(1));
    chk("ld_cmd",   160'(bus_if.exe_exe_cmd), 160'(2));
    chk("ld_val_rn",160'(bus_if.exe_val_rn), 160'(32'h10));
    chk("ld_valid", 160'(bus_if.exe_valid), 160'(1));
    chk("ld_mem_w", 160'(bus_if.exe_mem_w_en), 160'(0));

    // freeze for 3 cycles while id_dest walks
    bus_if.freeze = 1'b1;
    bus_if.id_dest = 4'h8; step();
    chk("frz1_dest", 160'(bus_if.exe_dest), 160'(7));
    bus_if.id_dest = 4'h9; step();
    chk("frz2_dest", 160'(bus_if.exe_dest), 160'(7));
    bus_if.id_dest = 4'hA; step();
    chk("frz3_dest", 160'(bus_if.exe_dest), 160'(7));
    chk("frz3_valid",160'(bus_if.exe_valid), 160'(1));
    bus_if.freeze = 1'b0;
    step();
    chk("unfrz_dest", 160'(bus_if.exe_dest), 160'(4'hA));

    // flush one cycle
    bus_if.id_wb_en = 1'b1; bus_if.id_mem_w_en = 1'b1; bus_if.id_dest = 4'd2;
    step();
    chk("pre_fl_dest",  160'(bus_if.exe_dest), 160'(2));
    chk("pre_fl_mem_w", 160'(bus_if.exe_mem_w_en), 160'(1));
    bus_if.flush = 1'b1; bus_if.id_dest = 4'd3;
    step();
    chk("fl_wb_en", 160'(bus_if.exe_wb_en), 160'(0));
    chk("fl_mem_w", 160'(bus_if.exe_mem_w_en), 160'(0));
    chk("fl_dest",  160'(bus_if.exe_dest), 160'(0));
    chk("fl_valid", 160'(bus_if.exe_valid), 160'(0));
    chk("fl_word",  exe_word(), 160'(0));
    bus_if.flush = 1'b0; bus_if.id_dest = 4'd4;
    step();
    chk("post_fl_dest",  160'(bus_if.exe_dest), 160'(4));
    chk("post_fl_wb_en", 160'(bus_if.exe_wb_en), 160'(1));
    chk("post_fl_valid", 160'(bus_if.exe_valid), 160'(1));

    // flush together with freeze, then bubble held under freeze
    bus_if.flush = 1'b1; bus_if.freeze = 1'b1;
    step();
    chk("flfz_valid", 160'(bus_if.exe_valid), 160'(0));
    chk("flfz_word",  exe_word(), 160'(0));
    bus_if.flush = 1'b0; bus_if.id_dest = 4'd5;
    step();
    chk("hold1_valid", 160'(bus_if.exe_valid), 160'(0));
    step();
    chk("hold2_valid", 160'(bus_if.exe_valid), 160'(0));
    chk("hold2_word",  exe_word(), 160'(0));
    bus_if.freeze = 1'b0;
    step();
    chk("flfz_rel_dest",  160'(bus_if.exe_dest), 160'(5));
    chk("flfz_rel_valid", 160'(bus_if.exe_valid), 160'(1));

    // reset in the middle of a stall
    bus_if.id_dest = 4'd6;
    step();
    chk("pre_rst_dest", 160'(bus_if.exe_dest), 160'(6));
    bus_if.freeze = 1'b1; rst = 1'b1;
    step();
    chk("rst_stall_word",  exe_word(), 160'(0));
    chk("rst_stall_valid", 160'(bus_if.exe_valid), 160'(0));
    rst = 1'b0;
    step();
    chk("rst_frz_word",  exe_word(), 160'(0));
    chk("rst_frz_valid", 160'(bus_if.exe_valid), 160'(0));
    bus_if.freeze = 1'b0;
    step();
    chk("rst_rel_dest",  160'(bus_if.exe_dest), 160'(6));
    chk("rst_rel_valid", 160'(bus_if.exe_valid), 160'(1));

    // every field copied exactly with distinct values
    bus_if.id_wb_en = 1'b1; bus_if.id_mem_r_en = 1'b1; bus_if.id_mem_w_en = 1'b0;
    bus_if.id_b = 1'b1; bus_if.id_s = 1'b0; bus_if.id_exe_cmd = 4'hB;
    bus_if.id_pc = 32'h0000_1004; bus_if.id_val_rn = 32'hDEAD_BEEF;
    bus_if.id_val_rm = 32'h1234_5678; bus_if.id_imm = 1'b1;
    bus_if.id_shift_operand = 12'hA5C; bus_if.id_signed_imm_24 = 24'h80_0001;
    bus_if.id_dest = 4'h9; bus_if.id_src1 = 4'h1; bus_if.id_src2 = 4'hE;
    bus_if.id_sr = 4'b1010;
    exp_word = 160'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 32'h0000_1004,
                     32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 12'hA5C, 24'h80_0001,
                     4'h9, 4'h1, 4'hE, 4'b1010});
    step();
    chk("fields_word",   exe_word(), exp_word);
    chk("fields_imm24",  160'(bus_if.exe_signed_imm_24), 160'(24'h80_0001));
    chk("fields_val_rm", 160'(bus_if.exe_val_rm), 160'(32'h1234_5678));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
